// File: rtl/mem_req_ctrl_if.sv
// Host request/response and memory-stage signals of the request sequencer.
// The slave modport is the controller's view; the master modport is the surrounding host and memory stage.
interface mem_req_ctrl_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 31
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  err_sticky;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  mem_valid;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout, mem_valid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, err_sticky,
               mem_addr, mem_en, mem_we, mem_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout, mem_valid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_sticky,
               mem_addr, mem_en, mem_we, mem_din
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Single-outstanding request sequencer in front of the latency-wrapped block-RAM stage.
// Issues a one-cycle mem_en per request, waits for mem_valid on reads (with timeout) and holds the response until taken.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | req_ready high; a valid request is latched onto mem_addr/we/din
// ISSUE   | mem_en pulse; writes return to IDLE, reads arm the timeout
// RD_WAIT | waiting for mem_valid or timeout, mem_addr held
// RSP     | rsp_valid high, response held until rsp_ready
module mem_req_ctrl #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 31,
    parameter int READ_LATENCY = 3,
    parameter int TIMEOUT      = 15,
    parameter int TO_W         = 4
) (
    input logic           clk_a,
    input logic           arstz_aq,
    mem_req_ctrl_if.slave bus
);

    // A timeout shorter than the memory latency would fail every read, so clamp it.
    localparam int              TO_LAST_I = (TIMEOUT > READ_LATENCY) ? TIMEOUT - 1 : READ_LATENCY;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LAST_I);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RSP     = 2'd3
    } state_t;

    logic [1:0]            rst_sync_q, rst_sync_d;
    logic                  rst_b;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_en_q, mem_en_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  err_sticky_q, err_sticky_d;

    // Assertion takes effect at once; release is retimed to clk_a.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_b = rst_sync_q[1];

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_we_d     = 1'b0;
        to_cnt_d     = to_cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        err_sticky_d = err_sticky_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    mem_addr_d = bus.req_addr;
                    mem_din_d  = bus.req_wdata;
                    mem_we_d   = bus.req_we;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                to_cnt_d = '0;
                state_d  = mem_we_q ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                // Late data on the last allowed cycle still counts as a good read.
                if (bus.mem_valid) begin
                    rsp_rdata_d = bus.mem_dout;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else if (to_cnt_q == TO_LAST) begin
                    rsp_rdata_d  = '0;
                    rsp_err_d    = 1'b1;
                    err_sticky_d = 1'b1;
                    rsp_valid_d  = 1'b1;
                    state_d      = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_en_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk_a or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            to_cnt_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_we_q     <= mem_we_d;
            mem_en_q     <= mem_en_d;
            to_cnt_q     <= to_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_din    = mem_din_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed plus randomized bench for mem_req_ctrl with a latency-programmable memory-stage model.
// Expected responses come from a shadow memory and the latency/timeout rules, not from the design.
module tb_mem_req_ctrl;

    localparam int AW  = 15;
    localparam int DW  = 31;
    localparam int RL  = 3;
    localparam int TO  = 15;
    localparam int TOW = 4;

    logic clk_a = 1'b0;
    logic arstz_aq = 1'b0;

    always #5 clk_a = ~clk_a;

    mem_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_req_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .TIMEOUT(TO), .TO_W(TOW)
    ) dut (
        .clk_a    (clk_a),
        .arstz_aq (arstz_aq),
        .bus      (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Memory stage model: data sampled at the mem_en pulse, mem_valid env_delay cycles later (0 = never).
    int            env_delay = RL;
    int            env_cnt   = 0;
    int            spur_n    = 0;
    int            spur_done = 0;
    logic          env_valid = 1'b0;
    logic [DW-1:0] env_dout  = '0;
    logic [DW-1:0] env_rd    = '0;
    logic [DW-1:0] env_mem [logic [AW-1:0]];

    assign bus.mem_valid = env_valid;
    assign bus.mem_dout  = env_dout;

    always @(negedge clk_a) begin
        env_valid = 1'b0;
        if (spur_n != spur_done) begin
            env_valid = 1'b1;
            env_dout  = DW'($urandom);
            spur_done = spur_n;
        end
        if (env_cnt > 0) begin
            env_cnt = env_cnt - 1;
            if (env_cnt == 0) begin
                env_valid = 1'b1;
                env_dout  = env_rd;
            end
        end
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1) begin
                env_mem[bus.mem_addr] = bus.mem_din;
            end else begin
                env_rd  = env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr] : '0;
                env_cnt = env_delay;
            end
        end
    end

    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic          ref_sticky = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check("req_ready_before", 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk_a);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = DW'($urandom);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        send_req(1'b1, a, d);
        @(negedge clk_a);
        check("wr_c1_ctrl", 64'({bus.mem_en, bus.mem_we, bus.req_ready}), 64'(3'b110));
        check("wr_c1_addr", 64'(bus.mem_addr), 64'(a));
        check("wr_c1_din", 64'(bus.mem_din), 64'(d));
        @(negedge clk_a);
        check("wr_c2_ctrl", 64'({bus.mem_en, bus.mem_we, bus.req_ready}), 64'(3'b001));
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int delay, input int hold);
        bit            exp_ok;
        int            exp_cyc;
        logic [DW-1:0] exp_data;
        bit            got;
        int            n;
        exp_ok   = (delay >= 1) && (delay <= TO);
        exp_cyc  = exp_ok ? delay + 2 : TO + 2;
        exp_data = exp_ok ? (ref_mem.exists(a) ? ref_mem[a] : '0) : '0;
        env_delay = delay;
        send_req(1'b0, a, DW'($urandom));
        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            @(negedge clk_a);
            n++;
            if (n == 1) begin
                check("rd_c1_ctrl", 64'({bus.mem_en, bus.mem_we, bus.req_ready, bus.rsp_valid}), 64'(4'b1000));
                check("rd_c1_addr", 64'(bus.mem_addr), 64'(a));
            end else if (bus.rsp_valid !== 1'b1) begin
                check("rd_wait", 64'({bus.mem_en, bus.mem_we, bus.req_ready, bus.mem_addr}),
                      64'({3'b000, a}));
            end
            if (bus.rsp_valid === 1'b1) got = 1'b1;
        end
        check("rd_rsp_seen", 64'(got), 64'(1));
        check("rd_rsp_cycle", 64'(n), 64'(exp_cyc));
        check("rd_rsp_data", 64'(bus.rsp_rdata), 64'(exp_data));
        check("rd_rsp_err", 64'(bus.rsp_err), 64'(!exp_ok));
        if (!exp_ok) ref_sticky = 1'b1;
        check("rd_sticky", 64'(bus.err_sticky), 64'(ref_sticky));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_a);
            check("bp_hold", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready, bus.mem_en}),
                  64'({1'b1, !exp_ok, exp_data, 1'b0, 1'b0}));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk_a);
        bus.rsp_ready = 1'b0;
        check("rsp_release", 64'({bus.rsp_valid, bus.req_ready}), 64'(2'b01));
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            dly;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_a);
        check("rst_ctrl", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.err_sticky, bus.mem_en, bus.mem_we}),
              64'(6'b100000));
        check("rst_rdata", 64'(bus.rsp_rdata), 64'(0));
        check("rst_addr_din", 64'({bus.mem_addr, bus.mem_din}), 64'(0));
        arstz_aq = 1'b1;
        repeat (4) @(negedge clk_a);
        check("post_rst_idle", 64'({bus.req_ready, bus.rsp_valid, bus.mem_en}), 64'(3'b100));

        // Directed write then read-back, nominal latency then with backpressure
        do_write(15'h0010, 31'h1234_5678);
        do_read(15'h0010, RL, 0);
        do_read(15'h0010, RL, 6);

        // Spurious mem_valid while idle must not move the controller
        spur_n++;
        @(negedge clk_a);
        @(negedge clk_a);
        check("spur_idle", 64'({bus.req_ready, bus.rsp_valid, bus.mem_en, bus.rsp_err}), 64'(4'b1000));

        // mem_valid on the timeout cycle is data; one cycle later is a timeout
        do_write(15'h0123, 31'h0ABC_DEF1);
        do_read(15'h0123, TO, 1);
        check("sticky_clear", 64'(bus.err_sticky), 64'(0));
        do_read(15'h0123, TO + 1, 2);
        do_read(15'h0010, 0, 0);
        do_read(15'h0010, RL, 0);

        // Random mix over a small address pool so reads hit earlier writes
        for (int t = 0; t < 40; t++) begin
            a = AW'($urandom_range(0, 7)) << 4;
            if ($urandom_range(0, 2) == 0) begin
                d = DW'($urandom);
                do_write(a, d);
            end else begin
                dly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO + 2);
                do_read(a, dly, $urandom_range(0, 3));
            end
        end

        // Reset in the middle of a read aborts it without a response
        env_delay = RL;
        send_req(1'b0, 15'h0010, '0);
        @(negedge clk_a);
        @(negedge clk_a);
        arstz_aq = 1'b0;
        #1;
        check("rst_mid_rd", 64'({bus.req_ready, bus.rsp_valid, bus.mem_en, bus.err_sticky}), 64'(4'b1000));
        ref_sticky = 1'b0;
        repeat (3) @(negedge clk_a);
        arstz_aq = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_a);
            check("rst_no_rsp", 64'({bus.req_ready, bus.rsp_valid, bus.mem_en, bus.err_sticky}), 64'(4'b1000));
        end
        do_write(15'h0040, 31'h5555_AAAA);
        do_read(15'h0040, RL, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
